// File: rtl/m6809_io_responder.sv
// 6809 bus target for the I/O card CPLD: 8-register window, E-clock stretch via MRDY,
// and a 16-bit interval timer with interrupt / acknowledge.
//
// state    | meaning
// S_IDLE   | waiting for a selected E rise
// S_WAIT   | holding MRDY low for WAIT_CYCLES hsclk cycles
// S_ACTIVE | access in progress; read data driven, write committed on E fall
module m6809_io_responder #(
    parameter int unsigned WAIT_CYCLES = 0,
    parameter logic [7:0]  DEVICE_ID   = 8'hA5
) (
    input  logic       hsclk,
    input  logic       rst_b,
    input  logic       sys_eclk,
    input  logic       csio_b,
    input  logic       rnw,
    input  logic [2:0] a,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       doe,
    output logic       mrdy_lo,
    output logic       irq_lo,
    input  logic       iack_b
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACTIVE} state_t;

    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    logic e_meta, e_sync, e_prev;
    logic cs_meta, cs_sync;
    logic iack_meta, iack_sync, iack_prev;
    logic e_rise, e_fall, iack_fall;

    state_t     state, state_nxt;
    logic [3:0] wait_cnt, wait_cnt_nxt;
    logic [2:0] addr_q;
    logic       rnw_q;
    logic       access_start, commit;
    logic       commit_wr, commit_rd, rd_en;

    logic        en, ie, oneshot, tf;
    logic        en_nxt, ie_nxt, oneshot_nxt, tf_nxt;
    logic        tf_set, tf_clr;
    logic [7:0]  reload_lo, reload_hi, scratch, shadow_hi;
    logic [15:0] count, count_nxt;
    logic [7:0]  wr_sel;
    logic        cnt_wr, tick;
    logic [7:0]  rd_data;

    // Idle levels: E low, select and acknowledge deasserted
    always_ff @(posedge hsclk or negedge rst_b) begin
        if (!rst_b) begin
            e_meta    <= 1'b0;
            e_sync    <= 1'b0;
            e_prev    <= 1'b0;
            cs_meta   <= 1'b1;
            cs_sync   <= 1'b1;
            iack_meta <= 1'b1;
            iack_sync <= 1'b1;
            iack_prev <= 1'b1;
        end else begin
            e_meta    <= sys_eclk;
            e_sync    <= e_meta;
            e_prev    <= e_sync;
            cs_meta   <= csio_b;
            cs_sync   <= cs_meta;
            iack_meta <= iack_b;
            iack_sync <= iack_meta;
            iack_prev <= iack_sync;
        end
    end

    assign e_rise    = e_sync & ~e_prev;
    assign e_fall    = ~e_sync & e_prev;
    assign iack_fall = ~iack_sync & iack_prev;

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        access_start = 1'b0;
        commit       = 1'b0;
        case (state)
            S_IDLE: begin
                if (e_rise && !cs_sync) begin
                    access_start = 1'b1;
                    if (WAIT_CYCLES > 0) begin
                        state_nxt    = S_WAIT;
                        wait_cnt_nxt = WAIT_LOAD;
                    end else begin
                        state_nxt = S_ACTIVE;
                    end
                end
            end
            S_WAIT: begin
                if (cs_sync) begin
                    state_nxt = S_IDLE;
                end else if (e_fall || wait_cnt == 4'd0) begin
                    state_nxt = S_ACTIVE;
                end else begin
                    wait_cnt_nxt = wait_cnt - 4'd1;
                end
            end
            S_ACTIVE: begin
                // deselect wins over a coincident E fall: nothing is committed
                if (cs_sync) begin
                    state_nxt = S_IDLE;
                end else if (e_fall) begin
                    state_nxt = S_IDLE;
                    commit    = 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge hsclk or negedge rst_b) begin
        if (!rst_b) begin
            state    <= S_IDLE;
            wait_cnt <= 4'd0;
            addr_q   <= 3'd0;
            rnw_q    <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            if (access_start) begin
                addr_q <= a;
                rnw_q  <= rnw;
            end
        end
    end

    assign mrdy_lo   = (state == S_WAIT);
    assign commit_wr = commit & ~rnw_q;
    assign commit_rd = commit & rnw_q;
    assign rd_en     = (state == S_ACTIVE) && (state_nxt == S_ACTIVE) && rnw_q;

    always_comb begin
        wr_sel = 8'd0;
        if (commit_wr) begin
            wr_sel[addr_q] = 1'b1;
        end
    end

    assign cnt_wr = wr_sel[4] | wr_sel[5];
    assign tick   = e_fall & en & ~cnt_wr;

    // Timer step first, then bus writes override; a TF set outranks any clear
    always_comb begin
        count_nxt   = count;
        en_nxt      = en;
        ie_nxt      = ie;
        oneshot_nxt = oneshot;
        tf_set      = 1'b0;
        tf_clr      = 1'b0;
        if (tick) begin
            if (count == 16'd1) begin
                tf_set = 1'b1;
                if (oneshot) begin
                    en_nxt    = 1'b0;
                    count_nxt = 16'd0;
                end else begin
                    count_nxt = {reload_hi, reload_lo};
                end
            end else begin
                count_nxt = count - 16'd1;
            end
        end
        if (wr_sel[0]) begin
            en_nxt      = din[0];
            ie_nxt      = din[1];
            oneshot_nxt = din[2];
            if (din[0] && !en) begin
                count_nxt = {reload_hi, reload_lo};
            end
        end
        if (wr_sel[4]) begin
            count_nxt = {count[15:8], din};
        end
        if (wr_sel[5]) begin
            count_nxt = {din, count[7:0]};
        end
        if (wr_sel[1] && din[0]) begin
            tf_clr = 1'b1;
        end
        if (iack_fall && irq_lo) begin
            tf_clr = 1'b1;
        end
        tf_nxt = tf_set | (tf & ~tf_clr);
    end

    always_ff @(posedge hsclk or negedge rst_b) begin
        if (!rst_b) begin
            en        <= 1'b0;
            ie        <= 1'b0;
            oneshot   <= 1'b0;
            tf        <= 1'b0;
            count     <= 16'd0;
            reload_lo <= 8'd0;
            reload_hi <= 8'd0;
            scratch   <= 8'd0;
            shadow_hi <= 8'd0;
            irq_lo    <= 1'b0;
        end else begin
            en      <= en_nxt;
            ie      <= ie_nxt;
            oneshot <= oneshot_nxt;
            tf      <= tf_nxt;
            count   <= count_nxt;
            irq_lo  <= tf_nxt & ie_nxt;
            if (wr_sel[2]) reload_lo <= din;
            if (wr_sel[3]) reload_hi <= din;
            if (wr_sel[6]) scratch   <= din;
            // high byte captured alongside the low byte the CPU just read
            if (commit_rd && addr_q == 3'd4) shadow_hi <= count[15:8];
        end
    end

    always_comb begin
        rd_data = 8'h00;
        case (addr_q)
            3'd0:    rd_data = {5'd0, oneshot, ie, en};
            3'd1:    rd_data = {7'd0, tf};
            3'd2:    rd_data = reload_lo;
            3'd3:    rd_data = reload_hi;
            3'd4:    rd_data = count[7:0];
            3'd5:    rd_data = shadow_hi;
            3'd6:    rd_data = scratch;
            3'd7:    rd_data = DEVICE_ID;
            default: rd_data = 8'h00;
        endcase
    end

    always_ff @(posedge hsclk or negedge rst_b) begin
        if (!rst_b) begin
            doe  <= 1'b0;
            dout <= 8'h00;
        end else begin
            doe  <= rd_en;
            dout <= rd_en ? rd_data : 8'h00;
        end
    end

endmodule

// File: tb/tb_m6809_io_responder.sv
// Randomised bus cycles against a register/timer reference model; read data is
// scoreboarded and compared whenever the responder enables its data bus.
module tb_m6809_io_responder;

    localparam int WAIT = 4;

    logic       hsclk;
    logic       rst_b;
    logic       sys_eclk;
    logic       csio_b;
    logic       rnw;
    logic [2:0] a;
    logic [7:0] din;
    logic [7:0] dout;
    logic       doe;
    logic       mrdy_lo;
    logic       irq_lo;
    logic       iack_b;

    m6809_io_responder #(.WAIT_CYCLES(WAIT), .DEVICE_ID(8'hA5)) dut (
        .hsclk(hsclk), .rst_b(rst_b), .sys_eclk(sys_eclk), .csio_b(csio_b),
        .rnw(rnw), .a(a), .din(din), .dout(dout), .doe(doe),
        .mrdy_lo(mrdy_lo), .irq_lo(irq_lo), .iack_b(iack_b)
    );

    initial begin
        hsclk = 1'b0;
        forever #5 hsclk = ~hsclk;
    end

    int n_vec  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // reference model of the register window and timer
    bit          m_en, m_ie, m_os, m_tf;
    logic [15:0] m_rl, m_cnt;
    logic [7:0]  m_scr, m_shadow;

    function automatic logic [7:0] m_read(input logic [2:0] adr);
        case (adr)
            3'd0: return {5'd0, m_os, m_ie, m_en};
            3'd1: return {7'd0, m_tf};
            3'd2: return m_rl[7:0];
            3'd3: return m_rl[15:8];
            3'd4: return m_cnt[7:0];
            3'd5: return m_shadow;
            3'd6: return m_scr;
            default: return 8'hA5;
        endcase
    endfunction

    task automatic m_reset();
        m_en = 0; m_ie = 0; m_os = 0; m_tf = 0;
        m_rl = 0; m_cnt = 0; m_scr = 0; m_shadow = 0;
    endtask

    task automatic m_efall(input bit wr, input bit snap, input logic [2:0] adr, input logic [7:0] dat);
        logic [15:0] old_cnt;
        bit          old_en, set;
        old_cnt = m_cnt;
        old_en  = m_en;
        set     = 0;
        if (old_en && !(wr && (adr == 3'd4 || adr == 3'd5))) begin
            if (old_cnt == 16'd1) begin
                set = 1;
                if (m_os) begin
                    m_en  = 0;
                    m_cnt = 16'd0;
                end else begin
                    m_cnt = m_rl;
                end
            end else begin
                m_cnt = old_cnt - 16'd1;
            end
        end
        if (snap) m_shadow = old_cnt[15:8];
        if (wr) begin
            case (adr)
                3'd0: begin
                    if (dat[0] && !old_en) m_cnt = m_rl;
                    m_en = dat[0]; m_ie = dat[1]; m_os = dat[2];
                end
                3'd1: if (dat[0]) m_tf = 0;
                3'd2: m_rl[7:0]  = dat;
                3'd3: m_rl[15:8] = dat;
                3'd4: m_cnt = {old_cnt[15:8], dat};
                3'd5: m_cnt = {dat, old_cnt[7:0]};
                3'd6: m_scr = dat;
                default: ;
            endcase
        end
        if (set) m_tf = 1;
    endtask

    // scoreboard + monitor
    logic [7:0] sb_q[$];
    logic [7:0] sb_cur;
    bit         doe_q = 0;
    int         mrdy_run = 0;

    always @(negedge hsclk) begin
        if (doe && !doe_q) begin
            if (sb_q.size() == 0) begin
                check("doe_unexpected", 32'(doe), 32'(0));
            end else begin
                sb_cur = sb_q.pop_front();
                check("rd_data", 32'(dout), 32'(sb_cur));
            end
        end else if (doe) begin
            check("rd_hold", 32'(dout), 32'(sb_cur));
        end
        doe_q = doe;
        if (mrdy_lo) begin
            mrdy_run++;
        end else begin
            if (mrdy_run != 0) check("mrdy_len", 32'(mrdy_run), 32'(WAIT));
            mrdy_run = 0;
        end
    end

    // mode: 0 normal, 1 deselect mid-access, 2 reset mid-access
    task automatic bus_cycle(input bit sel, input bit rd, input logic [2:0] adr,
                             input logic [7:0] dat, input int mode, input bit iack);
        if (iack) begin
            check("irq_pre", 32'(irq_lo), 32'(m_tf & m_ie));
            iack_b = 1'b0;
            if (m_tf && m_ie) m_tf = 0;
            repeat (3) @(negedge hsclk);
            check("irq_iack", 32'(irq_lo), 32'(m_tf & m_ie));
            iack_b = 1'b1;
            repeat (2) @(negedge hsclk);
        end
        a = adr; rnw = rd; din = dat;
        csio_b = ~sel;
        if (sel && rd) sb_q.push_back(m_read(adr));
        repeat (6) @(negedge hsclk);
        sys_eclk = 1'b1;
        if (mode == 2) begin
            repeat (14) @(negedge hsclk);
            rst_b = 1'b0;
            #1;
            check("rst_doe", 32'(doe), 32'(0));
            check("rst_dout", 32'(dout), 32'(0));
            check("rst_mrdy", 32'(mrdy_lo), 32'(0));
            check("rst_irq", 32'(irq_lo), 32'(0));
            repeat (10) @(negedge hsclk);
            sys_eclk = 1'b0;
            repeat (4) @(negedge hsclk);
            csio_b = 1'b1;
            repeat (2) @(negedge hsclk);
            rst_b = 1'b1;
            m_reset();
            repeat (2) @(negedge hsclk);
            return;
        end
        if (mode == 1) begin
            repeat (12) @(negedge hsclk);
            csio_b = 1'b1;
            repeat (12) @(negedge hsclk);
        end else begin
            repeat (24) @(negedge hsclk);
        end
        sys_eclk = 1'b0;
        m_efall(sel && !rd && mode == 0, sel && rd && mode == 0 && adr == 3'd4, adr, dat);
        repeat (4) @(negedge hsclk);
        csio_b = 1'b1;
        repeat (2) @(negedge hsclk);
        check("irq_level", 32'(irq_lo), 32'(m_tf & m_ie));
    endtask

    task automatic wr(input logic [2:0] adr, input logic [7:0] dat);
        bus_cycle(1, 0, adr, dat, 0, 0);
    endtask

    task automatic rd(input logic [2:0] adr);
        bus_cycle(1, 1, adr, 8'h00, 0, 0);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) bus_cycle(0, 1, 3'd0, 8'h00, 0, 0);
    endtask

    initial begin
        logic [2:0] adr;
        logic [7:0] dat;
        int         r;
        rst_b = 1'b0; sys_eclk = 1'b0; csio_b = 1'b1; iack_b = 1'b1;
        rnw = 1'b1; a = 3'd0; din = 8'h00;
        m_reset();
        repeat (3) @(negedge hsclk);
        check("reset_doe", 32'(doe), 32'(0));
        check("reset_dout", 32'(dout), 32'(0));
        check("reset_mrdy", 32'(mrdy_lo), 32'(0));
        check("reset_irq", 32'(irq_lo), 32'(0));
        rst_b = 1'b1;
        repeat (3) @(negedge hsclk);

        wr(3'd6, 8'h3C); rd(3'd6); rd(3'd7);

        wr(3'd2, 8'h03); wr(3'd3, 8'h00); wr(3'd0, 8'h03);
        idle(3);
        rd(3'd1); rd(3'd4);
        bus_cycle(0, 1, 3'd0, 8'h00, 0, 1);
        rd(3'd1);

        wr(3'd0, 8'h00); wr(3'd1, 8'h01); wr(3'd2, 8'h02); wr(3'd0, 8'h05);
        idle(3);
        rd(3'd0); rd(3'd4); rd(3'd5); rd(3'd1);

        wr(3'd0, 8'h00); wr(3'd2, 8'hFF); wr(3'd3, 8'h12); wr(3'd0, 8'h01);
        rd(3'd4); rd(3'd5);
        wr(3'd0, 8'h00); wr(3'd4, 8'h34); wr(3'd5, 8'h56); rd(3'd4); rd(3'd5);

        bus_cycle(1, 0, 3'd6, 8'h55, 1, 0);
        rd(3'd6);

        bus_cycle(1, 1, 3'd6, 8'h00, 2, 0);
        rd(3'd6); rd(3'd0); rd(3'd2);

        for (int i = 0; i < 260; i++) begin
            r   = $urandom_range(0, 99);
            adr = 3'($urandom_range(0, 7));
            dat = 8'($urandom);
            case (adr)
                3'd2: dat = 8'($urandom_range(1, 5));
                3'd3: dat = ($urandom_range(0, 3) == 0) ? 8'h01 : 8'h00;
                3'd4: dat = 8'($urandom_range(0, 6));
                3'd5: dat = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
                default: ;
            endcase
            if (r < 15)      bus_cycle(0, 1, adr, dat, 0, $urandom_range(0, 5) == 0);
            else if (r < 20) bus_cycle(1, 0, adr, dat, 1, 0);
            else if (r < 60) bus_cycle(1, 1, adr, dat, 0, $urandom_range(0, 7) == 0);
            else             bus_cycle(1, 0, adr, dat, 0, $urandom_range(0, 7) == 0);
        end

        repeat (20) @(negedge hsclk);
        check("sb_drain", 32'(sb_q.size()), 32'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
